// File: rtl/fwd_src_tracker_pkg.sv
// -----------------------------------------------------------------------------
// fwd_src_tracker_pkg
// Shared pipeline definitions for the forwarding-source tracker and for any
// consumer of its forwarding selects.
//
// Contents:
//   FWD_*          default widths/counts for the back-end pipeline
//   reg_idx_t      5-bit architectural register index
//   fwd_entry_t    one in-flight producer record {valid, rd[, lat]}
//
// Optional feature macro: FWD_LOAD_USE_STALL_EN
//   When defined, fwd_entry_t carries the result-ready stage (lat) so that
//   consumers can detect a producer whose result is not yet available.
// -----------------------------------------------------------------------------
package fwd_src_tracker_pkg;

    localparam int FWD_DATA_WIDTH = 32;
    localparam int FWD_SOURCE_NUM = 3;
    localparam int FWD_PIPE_NUM   = 2;
    localparam int FWD_RD_PORTS   = 2;

    // Stored latency width. Fixed at 4 bits so the entry layout does not
    // depend on a particular SOURCE_NUM (supports up to 15 stages).
    localparam int FWD_LAT_W      = 4;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic                 valid;
        reg_idx_t             rd;
`ifdef FWD_LOAD_USE_STALL_EN
        logic [FWD_LAT_W-1:0] lat;
`endif
    } fwd_entry_t;

endpackage : fwd_src_tracker_pkg

// File: rtl/fwd_src_tracker_if.sv
// -----------------------------------------------------------------------------
// fwd_src_tracker_if
// Groups the issue-side inputs and the per-port forwarding outputs of the
// forwarding-source tracker.
//
// Signals:
//   issue_valid_i [PIPE_NUM]                     instruction issued per pipe
//   issue_rd_i    [PIPE_NUM][5]                  destination register (r0 = none)
//   issue_lat_i   [PIPE_NUM][LAT_IN_W]           first stage with a valid result
//   stall_i                                      back-end hold
//   flush_i                                      kill all in-flight entries
//   rs_i          [PIPE_NUM][RD_PORTS][5]        source registers read at issue
//   sel_vec_o     [PIPE_NUM][RD_PORTS][SRC+1]    one-hot select, bit 0 = regfile
//   pipe_sel_o    [PIPE_NUM][RD_PORTS][PSEL_W]   producing pipe
//   hazard_o      [PIPE_NUM]                     producer found but not ready
//
// Handshake: there is no valid/ready pair. Issue inputs are sampled on every
// rising clk edge where stall_i and flush_i are low; outputs are a pure
// combinational function of the stored entries and rs_i, valid every cycle.
//
// Modports: master drives the issue side (issue stage / bench),
//           slave is the tracker.
// -----------------------------------------------------------------------------
interface fwd_src_tracker_if #(
    parameter int SOURCE_NUM = 3,
    parameter int PIPE_NUM   = 2,
    parameter int RD_PORTS   = 2
);
    localparam int LAT_IN_W = $clog2(SOURCE_NUM + 1);
    localparam int PSEL_W   = (PIPE_NUM > 1) ? $clog2(PIPE_NUM) : 1;

    logic [PIPE_NUM-1:0]                               issue_valid_i;
    logic [PIPE_NUM-1:0][4:0]                          issue_rd_i;
    logic [PIPE_NUM-1:0][LAT_IN_W-1:0]                 issue_lat_i;
    logic                                              stall_i;
    logic                                              flush_i;
    logic [PIPE_NUM-1:0][RD_PORTS-1:0][4:0]            rs_i;
    logic [PIPE_NUM-1:0][RD_PORTS-1:0][SOURCE_NUM:0]   sel_vec_o;
    logic [PIPE_NUM-1:0][RD_PORTS-1:0][PSEL_W-1:0]     pipe_sel_o;
    logic [PIPE_NUM-1:0]                               hazard_o;

    modport master (
        output issue_valid_i, issue_rd_i, issue_lat_i, stall_i, flush_i, rs_i,
        input  sel_vec_o, pipe_sel_o, hazard_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_i, issue_lat_i, stall_i, flush_i, rs_i,
        output sel_vec_o, pipe_sel_o, hazard_o
    );

endinterface : fwd_src_tracker_if

// File: rtl/fwd_src_tracker_match_prio.sv
// -----------------------------------------------------------------------------
// fwd_match_prio
// Youngest-producer search for one source-operand port.
//
// Ports:
//   rs_i        source register of this port
//   entries_i   all in-flight entries, [stage SOURCE_NUM:1][pipe]
//   sel_vec_o   one-hot forwarding select (bit 0 = register file)
//   pipe_sel_o  pipe of the selected producer (0 when none)
//   hazard_o    selected producer has not reached its ready stage
//
// Optional feature macro: FWD_LOAD_USE_STALL_EN (enables hazard detection;
// otherwise hazard_o is tied low and every producer counts as ready).
// -----------------------------------------------------------------------------
module fwd_match_prio
    import fwd_src_tracker_pkg::*;
#(
    parameter int SOURCE_NUM = 3,
    parameter int PIPE_NUM   = 2,
    parameter int PSEL_W     = 1
) (
    input  reg_idx_t                                   rs_i,
    input  fwd_entry_t [SOURCE_NUM:1][PIPE_NUM-1:0]    entries_i,
    output logic [SOURCE_NUM:0]                        sel_vec_o,
    output logic [PSEL_W-1:0]                          pipe_sel_o,
    output logic                                       hazard_o
);

    logic              found;
    int                hit_s;
    logic [PSEL_W-1:0] hit_p;
    logic              late;

    always_comb begin
        found = 1'b0;
        hit_s = 0;
        hit_p = '0;
        late  = 1'b0;
        // Scan from oldest to youngest so the last hit is the youngest:
        // lowest stage wins, and within a stage the highest pipe wins.
        for (int s = SOURCE_NUM; s >= 1; s--) begin
            for (int p = 0; p < PIPE_NUM; p++) begin
                if (entries_i[s][p].valid && (entries_i[s][p].rd == rs_i)) begin
                    found = 1'b1;
                    hit_s = s;
                    hit_p = PSEL_W'(p);
`ifdef FWD_LOAD_USE_STALL_EN
                    late  = (FWD_LAT_W'(s) < entries_i[s][p].lat);
`else
                    late  = 1'b0;
`endif
                end
            end
        end
        // r0 is hard-wired zero: never forward it.
        if (rs_i == 5'd0) begin
            found = 1'b0;
        end

        sel_vec_o  = '0;
        pipe_sel_o = '0;
        hazard_o   = 1'b0;
        if (!found) begin
            sel_vec_o[0] = 1'b1;
        end else begin
            pipe_sel_o = hit_p;
            if (late) begin
                // Result not produced yet: select nothing, flag the stall.
                hazard_o = 1'b1;
            end else begin
                sel_vec_o[hit_s] = 1'b1;
            end
        end
    end

endmodule : fwd_match_prio

// File: rtl/fwd_src_tracker.sv
// -----------------------------------------------------------------------------
// fwd_src_tracker
// Tracks in-flight register writers across SOURCE_NUM back-end stages and
// PIPE_NUM issue pipes, and for each source operand being read at issue
// reports which stage/pipe should forward the value.
//
// Ports:
//   clk   single clock
//   rst   asynchronous active-high reset (clears all entries)
//   bus   fwd_src_tracker_if.slave: issue inputs, stall/flush, source
//         registers, forwarding selects, pipe selects, hazard flags
//
// Parameters: DATA_WIDTH (no datapath here), SOURCE_NUM, PIPE_NUM, RD_PORTS.
//
// Optional feature macro: FWD_LOAD_USE_STALL_EN
//   Defined:   each entry stores the first ready stage; a youngest match
//              that is not ready yet raises hazard_o for the reading pipe
//              and drives an all-zero select for that port.
//   Undefined: no latency storage, hazard_o tied low.
//
// Operands produced by an older pipe of the same issue group are not seen
// here; the issue logic resolves those.
// -----------------------------------------------------------------------------
module fwd_src_tracker
    import fwd_src_tracker_pkg::*;
#(
    parameter int DATA_WIDTH = FWD_DATA_WIDTH,
    parameter int SOURCE_NUM = FWD_SOURCE_NUM,
    parameter int PIPE_NUM   = FWD_PIPE_NUM,
    parameter int RD_PORTS   = FWD_RD_PORTS
) (
    input logic              clk,
    input logic              rst,
    fwd_src_tracker_if.slave bus
);

    localparam int PSEL_W = (PIPE_NUM > 1) ? $clog2(PIPE_NUM) : 1;

    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("fwd_src_tracker: DATA_WIDTH must be positive");
    end

    fwd_entry_t [SOURCE_NUM:1][PIPE_NUM-1:0] entry_q;
    fwd_entry_t [SOURCE_NUM:1][PIPE_NUM-1:0] entry_d;

    // ---------------- entry shift register ----------------
    always_comb begin
        entry_d = entry_q;
        if (bus.flush_i) begin
            for (int s = 1; s <= SOURCE_NUM; s++) begin
                for (int p = 0; p < PIPE_NUM; p++) begin
                    entry_d[s][p].valid = 1'b0;
                end
            end
        end else if (!bus.stall_i) begin
            for (int s = SOURCE_NUM; s >= 2; s--) begin
                entry_d[s] = entry_q[s-1];
            end
            for (int p = 0; p < PIPE_NUM; p++) begin
                entry_d[1][p].valid = bus.issue_valid_i[p] && (bus.issue_rd_i[p] != 5'd0);
                entry_d[1][p].rd    = bus.issue_rd_i[p];
`ifdef FWD_LOAD_USE_STALL_EN
                entry_d[1][p].lat   = FWD_LAT_W'(bus.issue_lat_i[p]);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

`ifndef FWD_LOAD_USE_STALL_EN
    // Latency inputs have no consumer in this build.
    logic unused_lat;
    assign unused_lat = ^bus.issue_lat_i;
`endif

    // ---------------- per-port priority search ----------------
    logic [PIPE_NUM-1:0][RD_PORTS-1:0][SOURCE_NUM:0] sel_vec;
    logic [PIPE_NUM-1:0][RD_PORTS-1:0][PSEL_W-1:0]   pipe_sel;
    logic [PIPE_NUM-1:0][RD_PORTS-1:0]               port_haz;
    logic [PIPE_NUM-1:0]                             hazard;

    for (genvar gp = 0; gp < PIPE_NUM; gp++) begin : g_pipe
        for (genvar gr = 0; gr < RD_PORTS; gr++) begin : g_port
            fwd_match_prio #(
                .SOURCE_NUM (SOURCE_NUM),
                .PIPE_NUM   (PIPE_NUM),
                .PSEL_W     (PSEL_W)
            ) u_match (
                .rs_i       (bus.rs_i[gp][gr]),
                .entries_i  (entry_q),
                .sel_vec_o  (sel_vec[gp][gr]),
                .pipe_sel_o (pipe_sel[gp][gr]),
                .hazard_o   (port_haz[gp][gr])
            );
        end
        // A pipe stalls if any of its operands is waiting on a producer.
        assign hazard[gp] = |port_haz[gp];
    end

    assign bus.sel_vec_o  = sel_vec;
    assign bus.pipe_sel_o = pipe_sel;
    assign bus.hazard_o   = hazard;

endmodule : fwd_src_tracker

// File: tb/tb_fwd_src_tracker.sv
// -----------------------------------------------------------------------------
// tb_fwd_src_tracker
// Directed bench for fwd_src_tracker with default parameters. Driver tasks
// set inputs just after each rising edge and push the hand-computed expected
// per-port response into exp_q; a monitor on the falling edge pops and
// compares every queued expectation against the DUT outputs.
// Honors FWD_LOAD_USE_STALL_EN for the load-use hazard expectations.
// -----------------------------------------------------------------------------
module tb_fwd_src_tracker;

    localparam int SN = 3;
    localparam int PN = 2;
    localparam int RP = 2;
    localparam int W  = 8;   // {pipe, port, sel[3:0], pipe_sel, hazard}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_src_tracker_if #(.SOURCE_NUM(SN), .PIPE_NUM(PN), .RD_PORTS(RP)) bus ();

    fwd_src_tracker #(
        .DATA_WIDTH (32),
        .SOURCE_NUM (SN),
        .PIPE_NUM   (PN),
        .RD_PORTS   (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid_i = '0;
        bus.issue_rd_i    = '0;
        bus.issue_lat_i   = '0;
        bus.stall_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.rs_i          = '0;
    endtask

    task automatic issue(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic [1:0] lat0, input logic [1:0] lat1);
        bus.issue_valid_i = v;
        bus.issue_rd_i[0] = rd0;
        bus.issue_rd_i[1] = rd1;
        bus.issue_lat_i[0] = lat0;
        bus.issue_lat_i[1] = lat1;
    endtask

    task automatic read(input int p, input int r, input logic [4:0] rs);
        bus.rs_i[p][r] = rs;
    endtask

    task automatic expect_port(input int p, input int r, input logic [3:0] sel,
                               input logic psel, input logic haz);
        logic [31:0] pv;
        logic [31:0] rv;
        pv = p;
        rv = r;
        exp_q.push_back({pv[0], rv[0], sel, psel, haz});
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] m_item;
    int           m_p;
    int           m_r;
    logic [3:0]   m_sel;
    logic         m_psel;
    logic         m_haz;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_item = exp_q.pop_front();
            m_p    = int'(m_item[7]);
            m_r    = int'(m_item[6]);
            m_sel  = m_item[5:2];
            m_psel = m_item[1];
            m_haz  = m_item[0];
            n_checks++;
            if (bus.sel_vec_o[m_p][m_r] === m_sel &&
                bus.pipe_sel_o[m_p][m_r] === m_psel &&
                bus.hazard_o[m_p] === m_haz) begin
                n_pass++;
            end else begin
                $display("FAIL port[%0d][%0d] t=%0t: got sel=%b pipe_sel=%0d hazard=%b, expected sel=%b pipe_sel=%0d hazard=%b",
                         m_p, m_r, $time, bus.sel_vec_o[m_p][m_r], bus.pipe_sel_o[m_p][m_r],
                         bus.hazard_o[m_p], m_sel, m_psel, m_haz);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 1'b1;
        // Issue while in reset must be discarded.
        issue(2'b01, 5'd12, 5'd0, 2'd1, 2'd0);
        read(0, 0, 5'd12);
        repeat (2) @(posedge clk);
        #1;
        expect_port(0, 0, 4'b0001, 1'b0, 1'b0);
        expect_port(0, 1, 4'b0001, 1'b0, 1'b0);
        expect_port(1, 0, 4'b0001, 1'b0, 1'b0);
        expect_port(1, 1, 4'b0001, 1'b0, 1'b0);
        step();

        // Release reset; first shift happens on the next edge.
        rst = 1'b0;
        issue(2'b01, 5'd5, 5'd0, 2'd1, 2'd0);
        read(0, 0, 5'd12);
        expect_port(0, 0, 4'b0001, 1'b0, 1'b0);
        step();

        // rd=5 at stage 1, pipe 0.
        idle();
        read(1, 0, 5'd5);
        read(0, 1, 5'd5);
        read(0, 0, 5'd12);
        expect_port(1, 0, 4'b0010, 1'b0, 1'b0);
        expect_port(0, 1, 4'b0010, 1'b0, 1'b0);
        expect_port(0, 0, 4'b0001, 1'b0, 1'b0);
        // Both pipes write r7 in one group.
        issue(2'b11, 5'd7, 5'd7, 2'd1, 2'd1);
        step();

        idle();
        read(0, 0, 5'd7);
        read(1, 0, 5'd7);
        read(1, 1, 5'd5);
        expect_port(0, 0, 4'b0010, 1'b1, 1'b0);
        expect_port(1, 0, 4'b0010, 1'b1, 1'b0);
        expect_port(1, 1, 4'b0100, 1'b0, 1'b0);
        step();

        // rd=9 walks through all stages then retires.
        issue(2'b01, 5'd9, 5'd0, 2'd1, 2'd0);
        step();
        idle();
        read(0, 0, 5'd9);
        expect_port(0, 0, 4'b0010, 1'b0, 1'b0);
        step();
        read(0, 0, 5'd9);
        expect_port(0, 0, 4'b0100, 1'b0, 1'b0);
        step();
        read(0, 0, 5'd9);
        expect_port(0, 0, 4'b1000, 1'b0, 1'b0);
        step();
        read(0, 0, 5'd9);
        expect_port(0, 0, 4'b0001, 1'b0, 1'b0);

        // Lower stage beats higher pipe: r11 on p1, then r11 on p0.
        issue(2'b10, 5'd0, 5'd11, 2'd1, 2'd1);
        step();
        idle();
        issue(2'b01, 5'd11, 5'd0, 2'd1, 2'd0);
        read(0, 0, 5'd11);
        expect_port(0, 0, 4'b0010, 1'b1, 1'b0);
        step();
        idle();
        read(1, 1, 5'd11);
        expect_port(1, 1, 4'b0010, 1'b0, 1'b0);

        // rd=0 never creates a producer; rs=0 always reads the regfile.
        issue(2'b11, 5'd0, 5'd0, 2'd1, 2'd1);
        step();
        idle();
        read(0, 0, 5'd0);
        read(0, 1, 5'd20);
        read(1, 0, 5'd11);
        expect_port(0, 0, 4'b0001, 1'b0, 1'b0);
        expect_port(0, 1, 4'b0001, 1'b0, 1'b0);
        expect_port(1, 0, 4'b0100, 1'b0, 1'b0);
        step();

        // Stall holds rd=4 at stage 1 and ignores the issue of r13.
        idle();
        issue(2'b01, 5'd4, 5'd0, 2'd1, 2'd0);
        step();
        idle();
        bus.stall_i = 1'b1;
        issue(2'b01, 5'd13, 5'd0, 2'd1, 2'd0);
        read(0, 0, 5'd4);
        read(0, 1, 5'd13);
        expect_port(0, 0, 4'b0010, 1'b0, 1'b0);
        expect_port(0, 1, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_port(0, 0, 4'b0010, 1'b0, 1'b0);
            expect_port(0, 1, 4'b0001, 1'b0, 1'b0);
        end
        // Flush wins over stall and issue.
        bus.flush_i = 1'b1;
        issue(2'b01, 5'd14, 5'd0, 2'd1, 2'd0);
        step();
        idle();
        read(0, 0, 5'd4);
        read(1, 0, 5'd14);
        read(1, 1, 5'd13);
        expect_port(0, 0, 4'b0001, 1'b0, 1'b0);
        expect_port(1, 0, 4'b0001, 1'b0, 1'b0);
        expect_port(1, 1, 4'b0001, 1'b0, 1'b0);

        // Load-use: rd=3 ready only from stage 2.
        issue(2'b01, 5'd3, 5'd0, 2'd2, 2'd0);
        step();
        idle();
        read(1, 0, 5'd3);
`ifdef FWD_LOAD_USE_STALL_EN
        expect_port(1, 0, 4'b0000, 1'b0, 1'b1);
`else
        expect_port(1, 0, 4'b0010, 1'b0, 1'b0);
`endif
        expect_port(0, 0, 4'b0001, 1'b0, 1'b0);
        step();
        read(1, 0, 5'd3);
        expect_port(1, 0, 4'b0100, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle clears a live entry.
        issue(2'b01, 5'd21, 5'd0, 2'd1, 2'd0);
        step();
        idle();
        read(0, 0, 5'd21);
        expect_port(0, 0, 4'b0010, 1'b0, 1'b0);
        step();
        read(0, 0, 5'd21);
        #1;
        rst = 1'b1;
        expect_port(0, 0, 4'b0001, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        step();

        // Everything queued must have been consumed.
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fwd_src_tracker

// File: doc/fwd_src_tracker.md
FWD_SRC_TRACKER -- requirements
Module: fwd_src_tracker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register data width; carried for package consistency only, no datapath.
REQ-002 SHALL have parameter SOURCE_NUM, default 3, meaning number of forwarding back-end stages, indexed 1..SOURCE_NUM.
REQ-003 SHALL have parameter PIPE_NUM, default 2, meaning issue pipes; pipe index order equals program order within an issue group.
REQ-004 SHALL have parameter RD_PORTS, default 2, meaning source operands per pipe.
REQ-005 SHALL have clk, input, 1, the single clock.
REQ-006 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have issue_valid_i, input, [PIPE_NUM], instruction issued this cycle per pipe.
REQ-008 SHALL have issue_rd_i, input, [PIPE_NUM][5], destination register per pipe; r0 means no write.
REQ-009 SHALL have issue_lat_i, input, [PIPE_NUM][$clog2(SOURCE_NUM+1)], first stage (1..SOURCE_NUM) at which the result is valid.
REQ-010 SHALL have stall_i, input, 1, back-end hold.
REQ-011 SHALL have flush_i, input, 1, kill all in-flight entries.
REQ-012 SHALL have rs_i, input, [PIPE_NUM][RD_PORTS][5], source registers being read at issue.
REQ-013 SHALL have sel_vec_o, output, [PIPE_NUM][RD_PORTS][SOURCE_NUM+1], one-hot forwarding select; bit 0 means register-file data.
REQ-014 SHALL have pipe_sel_o, output, [PIPE_NUM][RD_PORTS][$clog2(PIPE_NUM)], producing pipe.
REQ-015 SHALL have hazard_o, output, [PIPE_NUM], producer found but not yet ready.

Function
REQ-016 SHALL hold entry[s][p] = {valid, rd, lat} for s = 1..SOURCE_NUM, p = 0..PIPE_NUM-1.
REQ-017 SHALL, when !stall_i && !flush_i, load stage 1 from issue inputs, shift stage s into s+1, and retire stage SOURCE_NUM.
REQ-018 SHALL set valid on load only if issue_valid_i[p] and issue_rd_i[p] != 0.
REQ-019 SHALL hold all entries unchanged and ignore issue inputs while stall_i.
REQ-020 SHALL clear every valid bit on flush_i; flush wins over stall_i and issue in the same cycle.
REQ-021 SHALL compute outputs combinationally from current entries (zero latency).
REQ-022 SHALL select the youngest match: lowest stage s first, then highest pipe p within that stage.
REQ-023 SHALL drive sel_vec bit s and pipe_sel = p on a match; on no match or rs == 0, drive sel_vec = 1 (bit 0) and pipe_sel = 0.
REQ-024 SHALL guarantee sel_vec_o is exactly one-hot for every port.
REQ-025 SHALL exclude same-group dependencies (pipe 1 reading pipe 0's rd in the same issue cycle); these are resolved by issue logic.

Reset
REQ-026 SHALL clear all valid bits asynchronously on rst; outputs then read sel_vec = 1, pipe_sel = 0, hazard_o = 0.
REQ-027 SHALL discard a mid-operation issue coinciding with rst; the first shift occurs on the first clk edge after rst deasserts.

Configuration
REQ-028 SHALL, with FWD_LOAD_USE_STALL_EN defined, store lat and, on a youngest match at s < lat, assert hazard_o[pipe] and drive sel_vec = 0 for that port.
REQ-029 SHALL, without FWD_LOAD_USE_STALL_EN, omit lat storage and tie hazard_o to 0, treating every producer as ready at stage 1.

Structure
REQ-030 SHALL place the fwd_entry_t typedef and default SOURCE_NUM/PIPE_NUM constants in the shared pipeline package, shared with forwarding consumers.
REQ-031 SHALL implement the per-port youngest-match priority search as sub-module fwd_match_prio, instantiated PIPE_NUM*RD_PORTS times.

Verification
REQ-032 SHALL cover: issue p0 rd=5 lat=1, next cycle rs[1][0]=5 -> sel_vec=0b0010, pipe_sel=0, hazard=0.
REQ-033 SHALL cover: p0 and p1 both write rd=7 in one group, next cycle read 7 -> sel_vec=0b0010, pipe_sel=1.
REQ-034 SHALL cover: rd=9 issued, then two unrelated cycles -> sel_vec=0b1000; one more cycle -> sel_vec=0b0001.
REQ-035 SHALL cover: with the macro, load rd=3 lat=2, next cycle read 3 -> hazard_o=1, sel_vec=0; after one more cycle -> sel_vec=0b0100, hazard_o=0.
REQ-036 SHALL cover: stall_i for 3 cycles with rd=4 at stage 1 -> sel_vec stays 0b0010; flush_i with stall_i -> next cycle sel_vec=0b0001.
REQ-037 SHALL cover: rd=0 issued or rs=0 read -> sel_vec=0b0001 always.
